// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage: turns one load/store into a word-aligned
// req/ack bus transaction, stalls the pipeline until it retires, and returns extended load data.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_mem_write,
    input  logic [2:0]  i_mem_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_addr_err,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic             r_half;
    logic             r_byte;
    logic             r_signed;
    logic [1:0]       r_lane;
    logic [31:0]      r_bus_addr;
    logic [3:0]       r_bus_be;
    logic [31:0]      r_bus_wdata;
    logic [31:0]      r_rdata;
    logic             r_abort;

    logic        w_is_half;
    logic        w_is_byte;
    logic        w_signed;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    // Codes 101-111 fall through to word; signedness only matters for loads.
    assign w_is_half    = (i_mem_op == 3'b001) || (i_mem_op == 3'b010);
    assign w_is_byte    = (i_mem_op == 3'b011) || (i_mem_op == 3'b100);
    assign w_signed     = (i_mem_op == 3'b001) || (i_mem_op == 3'b011);
    assign w_misaligned = w_is_half ? i_addr[0] : (!w_is_byte && (i_addr[1:0] != 2'b00));
    assign w_accept     = (r_state == S_IDLE) && i_start && !w_misaligned;
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (w_is_half) begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_wdata[15:0]}};
        end else if (w_is_byte) begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
        end
    end

    // Shifting by the latched lane covers both halves and all four bytes.
    assign w_shift = i_bus_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_load = i_bus_rdata;
        if (r_byte)
            w_load = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
        else if (r_half)
            w_load = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_half      <= 1'b0;
            r_byte      <= 1'b0;
            r_signed    <= 1'b0;
            r_lane      <= 2'b00;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_abort     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= i_mem_write;
                        r_half      <= w_is_half;
                        r_byte      <= w_is_byte;
                        r_signed    <= w_signed;
                        r_lane      <= i_addr[1:0];
                        r_bus_addr  <= {i_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_cnt       <= '0;
                        r_abort     <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack in the timeout cycle still completes the access cleanly.
                    if (i_bus_ack) begin
                        if (!r_we) r_rdata <= w_load;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        if (!r_we) r_rdata <= '0;
                        r_cnt   <= '0;
                        r_abort <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall     = w_accept || (r_state == S_REQ);
    assign o_addr_err  = (r_state == S_IDLE) && i_start && w_misaligned;
    assign o_done      = (r_state == S_DONE);
    assign o_bus_err   = (r_state == S_DONE) && r_abort;
    assign o_bus_req   = (r_state == S_REQ);
    assign o_bus_we    = (r_state == S_REQ) && r_we;
    assign o_bus_be    = r_bus_be;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses checked
// cycle by cycle against an arithmetic reference model of the access rules.
module tb_mem_access_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_mem_write(mem_write),
        .i_mem_op(mem_op), .i_addr(addr), .i_wdata(wdata),
        .o_stall(stall), .o_done(done), .o_rdata(rdata), .o_addr_err(addr_err),
        .o_bus_err(bus_err), .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_be(bus_be),
        .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
        .i_bus_rdata(bus_rdata), .i_bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access from IDLE back to IDLE; ack_at >= TO means the bus never answers.
    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] rd, input int ack_at,
                          input logic start_in_done, output int nstall);
        int          size;
        logic        sgn, tmo;
        logic [31:0] ebe, ewd, v;
        size = (op == 3'd1 || op == 3'd2) ? 2 : (op == 3'd3 || op == 3'd4) ? 1 : 4;
        sgn  = (op == 3'd1 || op == 3'd3);
        ebe  = ((32'd1 << size) - 32'd1) << a[1:0];
        ewd  = (size == 4) ? w : (size == 2) ? {w[15:0], w[15:0]} : {4{w[7:0]}};
        nstall = 0;
        @(negedge clk);
        start = 1'b1; mem_write = we; mem_op = op; addr = a; wdata = w; bus_ack = 1'b0;
        #1;
        if ((a % size) != 0) begin
            chk("addr_err", addr_err, 1'b1);
            chk("mis_stall", stall, 1'b0);
            chk("mis_req", bus_req, 1'b0);
            @(negedge clk); start = 1'b0; #1;
            chk("mis_req_after", bus_req, 1'b0);
            chk("addr_err_pulse", addr_err, 1'b0);
            return;
        end
        chk("accept_stall", stall, 1'b1);
        chk("accept_noerr", addr_err, 1'b0);
        chk("accept_noreq", bus_req, 1'b0);
        nstall = 1;
        tmo = 1'b1;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            start = 1'b0;
            bus_ack = (k == ack_at);
            bus_rdata = (k == ack_at) ? rd : $urandom;
            #1;
            chk("req", bus_req, 1'b1);
            chk("req_stall", stall, 1'b1);
            chk("bus_we", bus_we, we);
            chk("bus_addr", bus_addr, {a[31:2], 2'b00});
            chk("bus_be", bus_be, ebe);
            chk("bus_wdata", bus_wdata, ewd);
            if (stall) nstall++;
            if (k == ack_at) begin
                tmo = 1'b0;
                break;
            end
        end
        if (!we) begin
            if (tmo) exp_rdata = '0;
            else begin
                v = rd >> (8 * a[1:0]);
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end
                exp_rdata = v;
            end
        end
        @(negedge clk);
        start = start_in_done; bus_ack = 1'($urandom);
        #1;
        chk("done", done, 1'b1);
        chk("bus_err", bus_err, tmo);
        chk("done_stall", stall, 1'b0);
        chk("done_req", bus_req, 1'b0);
        chk("rdata", rdata, exp_rdata);
        @(negedge clk);
        start = 1'b0; bus_ack = 1'b0;
        #1;
        chk("done_pulse", done, 1'b0);
        chk("bus_err_pulse", bus_err, 1'b0);
        chk("idle_req", bus_req, 1'b0);
        chk("idle_stall", stall, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        reset = 1'b1; start = 1'b0; mem_write = 1'b0; mem_op = 3'd0;
        addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_be", bus_be, 4'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_bus_err", bus_err, 1'b0);
        reset = 1'b0;

        access(1'b0, 3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, ns);
        chk("lw_stall_cycles", 32'(ns), 32'd4);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        access(1'b0, 3'd3, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, ns);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 1, 1'b1, ns);
        chk("lbu_rdata", rdata, 32'h00000080);
        access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0, ns);
        chk("sh_keeps_rdata", rdata, 32'h00000080);
        access(1'b0, 3'd0, 32'h101, 32'h0, 32'h0, 0, 1'b0, ns);
        access(1'b0, 3'd1, 32'h102, 32'h0, 32'h5678_9ABC, 0, 1'b0, ns);
        chk("lh_rdata", rdata, 32'h0000_5678);
        access(1'b1, 3'd0, 32'h300, 32'hCAFE_F00D, 32'h0, 99, 1'b0, ns);
        chk("timeout_stall_cycles", 32'(ns), 32'(TO + 1));
        access(1'b0, 3'd0, 32'h304, 32'h0, 32'h1111_2222, 99, 1'b0, ns);
        chk("timeout_load_zero", rdata, 32'h0);
        access(1'b0, 3'd2, 32'h306, 32'h0, 32'hF00F_0000, TO - 1, 1'b0, ns);
        chk("late_ack_lhu", rdata, 32'h0000_F00F);

        // Reset while the bus is being requested.
        @(negedge clk);
        start = 1'b1; mem_write = 1'b0; mem_op = 3'd0; addr = 32'h400;
        @(negedge clk);
        start = 1'b0; bus_ack = 1'b0;
        #1;
        chk("pre_rst_req", bus_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_rdata = '0;
        chk("rst_req_drop", bus_req, 1'b0);
        chk("rst_req_stall", stall, 1'b0);
        chk("rst_req_done", done, 1'b0);
        chk("rst_req_rdata", rdata, 32'h0);
        access(1'b0, 3'd0, 32'h400, 32'h0, 32'h0BAD_F00D, 1, 1'b0, ns);

        for (int i = 0; i < 60; i++) begin
            access(1'($urandom), 3'($urandom), {20'h0, 12'($urandom)}, $urandom, $urandom,
                   int'($urandom_range(0, 19)), 1'($urandom), ns);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
